// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared definitions for the debug-capable CPU register file.
//               Holds the default datapath geometry used by the CPU top level
//               and the dump streamer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

   // Default geometry of the CPU integer register file (32 x 64).
   localparam int c_DATA_W = 64;
   localparam int c_ADDR_W = 5;

   // Dump streamer state encoding.
   typedef logic [0:0] dump_state_t;
   localparam logic [0:0] c_ST_IDLE   = 1'b0;
   localparam logic [0:0] c_ST_STREAM = 1'b1;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_dump_ctrl
// Description : Sequencer that walks every register index once, presenting
//               one beat per index on a valid/ready handshake.
// Ports       : clock, reset      - clock, synchronous active-high reset
//               dump_start        - one-cycle request, honoured only in IDLE
//               dump_ready        - consumer accepts the current beat
//               dump_busy         - high while streaming
//               dump_valid        - current beat is valid
//               dump_index        - register index of the current beat
//               dump_last         - current beat is the final index
// Revision    : 1.0 - initial release
// ============================================================================
module rf_dump_ctrl
   import rf_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dump_start,
   input  logic              dump_ready,
   output logic              dump_busy,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_index,
   output logic              dump_last
);

   localparam logic [ADDR_W-1:0] c_LAST_IDX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] c_ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

   dump_state_t       r_state;
   logic [ADDR_W-1:0] r_index;
   logic              w_streaming;
   logic              w_last;

   assign w_streaming = (r_state == c_ST_STREAM);
   assign w_last      = w_streaming && (r_index == c_LAST_IDX);

   // The index is parked at 0 whenever the streamer is idle so that the
   // idle-state outputs need no extra masking.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_ST_IDLE;
         r_index <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (dump_start) begin
                  r_state <= c_ST_STREAM;
                  r_index <= '0;
               end
            end
            c_ST_STREAM: begin
               if (dump_ready) begin
                  if (w_last) begin
                     r_state <= c_ST_IDLE;
                     r_index <= '0;
                  end else begin
                     r_index <= r_index + c_ONE;
                  end
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
               r_index <= '0;
            end
         endcase
      end
   end

   assign dump_busy  = w_streaming;
   assign dump_valid = w_streaming;
   assign dump_index = r_index;
   assign dump_last  = w_last;

endmodule : rf_dump_ctrl
`default_nettype wire

// File: rtl/register_file_dbg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_dbg
// Description : Multi-read, single-write register file with write-to-read
//               bypass, optional hard-wired zero register and a debug dump
//               port that streams every register out over valid/ready.
// Ports       : clock, reset       - clock, synchronous active-high reset
//               rd_addr / rd_data  - N_RD packed combinational read ports
//               wr_en/addr/data    - single write port, commits on clock edge
//               dump_start         - begin streaming all registers
//               dump_busy/valid/ready/index/data/last - dump stream
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_dbg
   import rf_pkg::*;
#(
   parameter int DATA_W   = c_DATA_W,
   parameter int ADDR_W   = c_ADDR_W,
   parameter int N_RD     = 2,
   parameter bit ZERO_EN  = 1'b1,
   parameter int ZERO_IDX = 31
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_RD*ADDR_W-1:0]   rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     dump_start,
   output logic                     dump_busy,
   output logic                     dump_valid,
   input  logic                     dump_ready,
   output logic [ADDR_W-1:0]        dump_index,
   output logic [DATA_W-1:0]        dump_data,
   output logic                     dump_last
);

   localparam int                c_DEPTH    = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] c_ZERO_ADR = ADDR_W'(ZERO_IDX);

   logic [DATA_W-1:0] r_regs [c_DEPTH];
   logic              w_wr_commit;

   function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_EN && (a == c_ZERO_ADR);
   endfunction

   // Single read path shared by every read port and the dump port, so the
   // zero-register and bypass rules are applied identically everywhere.
   function automatic logic [DATA_W-1:0] f_read(
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] stored,
      input logic              commit,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      if (f_is_zero(a))
         return '0;
      else if (commit && (waddr == a))
         return wdata;
      else
         return stored;
   endfunction

   // A write only takes effect (and is only bypassed) when it will really
   // commit: reset wins over wr_en and the zero register swallows writes.
   assign w_wr_commit = wr_en && !reset && !f_is_zero(wr_addr);

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < c_DEPTH; i++)
            r_regs[i] <= '0;
      end else if (w_wr_commit) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];
      assign rd_data[p*DATA_W +: DATA_W] =
         f_read(w_addr, r_regs[w_addr], w_wr_commit, wr_addr, wr_data);
   end

   rf_dump_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_dump_ctrl (
      .clock      (clock),
      .reset      (reset),
      .dump_start (dump_start),
      .dump_ready (dump_ready),
      .dump_busy  (dump_busy),
      .dump_valid (dump_valid),
      .dump_index (dump_index),
      .dump_last  (dump_last)
   );

   // Dump data is a live read of the current index; forced to zero when idle.
   assign dump_data = dump_valid
                    ? f_read(dump_index, r_regs[dump_index], w_wr_commit, wr_addr, wr_data)
                    : '0;

endmodule : register_file_dbg
`default_nettype wire

// File: doc/register_file_dbg.md
REGISTER_FILE_DBG -- requirements
Module: register_file_dbg

Interface
REQ-001 DATA_W, 64, register width in bits.
REQ-002 ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 N_RD, 2, number of independent read ports (1..4).
REQ-004 ZERO_EN, 1, when 1 register ZERO_IDX is hard-wired to zero.
REQ-005 ZERO_IDX, 31, index of the hard-wired zero register.
REQ-006 clock  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 rd_addr  in  N_RD*ADDR_W  packed read addresses, port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 rd_data  out  N_RD*DATA_W  packed read data, same packing.
REQ-010 wr_en  in  1  write strobe.
REQ-011 wr_addr  in  ADDR_W  write address.
REQ-012 wr_data  in  DATA_W  write data.
REQ-013 dump_start  in  1  single-cycle request to stream out all registers.
REQ-014 dump_busy  out  1  high while a dump is in progress.
REQ-015 dump_valid  out  1  dump beat valid.
REQ-016 dump_ready  in  1  consumer accepts beat.
REQ-017 dump_index  out  ADDR_W  index of register on dump_data.
REQ-018 dump_data  out  DATA_W  register contents for current beat.
REQ-019 dump_last  out  1  high on beat with dump_index = DEPTH-1.

Function
REQ-020 Reads SHALL be combinational: rd_data[p] = reg[rd_addr[p]], zero latency.
REQ-021 Writes SHALL commit on the rising edge when wr_en=1; new value visible on reads the following cycle.
REQ-022 Same-cycle bypass: if wr_en=1 and wr_addr = rd_addr[p] (not the zero register), rd_data[p] SHALL equal wr_data.
REQ-023 With ZERO_EN=1, reads of ZERO_IDX SHALL return 0 and writes to it SHALL be discarded, including bypass and dump.
REQ-024 Dump FSM states SHALL be IDLE and STREAM only.
REQ-025 IDLE -> STREAM on dump_start=1; dump_index SHALL load 0; dump_busy and dump_valid assert the next cycle.
REQ-026 In STREAM, dump_valid SHALL stay 1 and dump_index/dump_data SHALL hold until dump_valid & dump_ready.
REQ-027 On a handshake with dump_last=0, dump_index SHALL increment by 1 the next cycle.
REQ-028 On a handshake with dump_last=1, the FSM SHALL return to IDLE; dump_busy and dump_valid deassert the next cycle.
REQ-029 dump_start while in STREAM SHALL be ignored.
REQ-030 dump_data SHALL be the live contents of reg[dump_index], including same-cycle write bypass per REQ-022.
REQ-031 Functional writes SHALL proceed normally during a dump; the dump never stalls writes or reads.
REQ-032 In IDLE, dump_valid=0, dump_last=0, dump_index=0, dump_data=0.

Reset
REQ-033 On reset, all DEPTH registers SHALL clear to 0 on the same edge.
REQ-034 Reset SHALL override wr_en and dump_start; FSM forced to IDLE, aborting any dump mid-stream with no further beats.
REQ-035 Outputs after reset: rd_data = 0 for all ports, dump_busy=0, dump_valid=0, dump_last=0, dump_index=0, dump_data=0.

Structure
REQ-036 Shared package rf_pkg SHALL hold the dump FSM state enumeration and default DATA_W/ADDR_W constants used by the CPU top level.
REQ-037 The dump streamer SHALL be a sub-module rf_dump_ctrl (FSM, index counter, last flag); the storage array and read/bypass muxes stay in the parent.
REQ-038 Default parameters SHALL make the block a drop-in for the existing 32x64, 2-read, XZR=31 CPU register file.

Verification
REQ-039 Reset, then read every address on both ports -> all 0; dump_busy=0.
REQ-040 Write 0xDEAD_BEEF_0000_0001 to r5; same cycle rd_addr[0]=5 -> 0xDEAD_BEEF_0000_0001 (bypass); next cycle reg read also matches.
REQ-041 Write 0xFFFF_FFFF_FFFF_FFFF to r31 -> rd_data of r31 = 0 on bypass cycle and after; dump beat 31 = 0.
REQ-042 Load rI = I+1 for I=0..30, dump_start, dump_ready=1 constantly -> 32 beats in 32 cycles, dump_data = index+1 (beat 31 = 0), dump_last only on index 31, busy drops after.
REQ-043 Dump with dump_ready toggling 1-of-3 cycles -> index/data held while ready=0, no beat skipped or duplicated; dump_start mid-stream ignored.
REQ-044 Assert reset at dump_index=10 -> next cycle dump_valid=0, dump_busy=0, all registers 0; a new dump_start restarts at index 0.
